// File: rtl/memseq_pkg.sv
// Shared types for the memseq byte-serial memory sequencer: FSM states,
// request size encodings and the size-to-byte-count helper.
package memseq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRaddr,
        StRwait,
        StRsample,
        StWsetup,
        StWstrobe,
        StDone
    } state_e;

    localparam logic [1:0] SizeByte   = 2'd0;
    localparam logic [1:0] SizeHalf   = 2'd1;
    localparam logic [1:0] SizeWord   = 2'd2;
    localparam logic [1:0] SizeDouble = 2'd3;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        n = 4'd1;
        unique case (size)
            SizeByte:   n = 4'd1;
            SizeHalf:   n = 4'd2;
            SizeWord:   n = 4'd4;
            SizeDouble: n = 4'd8;
            default:    n = 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/memseq_extend.sv
// Zero/sign extension of a right-aligned load result of the given size.
// Sign extension only exists when MEMSEQ_SIGNEXT_EN is defined.
module memseq_extend
    import memseq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [1:0]            size_i,
    input  logic                  signed_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    int unsigned nbits;
    logic        fill;

    always_comb begin
        nbits  = 32'(size_bytes(size_i)) * 8;
        fill   = 1'b0;
        data_o = '0;
`ifdef MEMSEQ_SIGNEXT_EN
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (signed_i && (i == nbits - 1)) begin
                fill = data_i[i];
            end
        end
`endif
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            data_o[i] = (i < nbits) ? data_i[i] : fill;
        end
    end

`ifndef MEMSEQ_SIGNEXT_EN
    logic unused_signed;
    assign unused_signed = signed_i;
`endif

endmodule

// File: rtl/memseq.sv
// Byte-serial big-endian load/store sequencer over an 8-bit memory port.
// Define MEMSEQ_SIGNEXT_EN to enable sign-extended loads (req_signed).
module memseq
    import memseq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]            mem_data_in,
    input  logic [7:0]            mem_data_out,
    output logic                  mem_write,
    input  logic                  mem_ready
);

    localparam logic [3:0] MaxBytes = 4'(DATA_WIDTH / 8);
    localparam logic [2:0] WaitInit = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [2:0]            wait_q, wait_d;
    logic [DATA_WIDTH-1:0] wsh_q, wsh_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0] acc_shift;
    logic [DATA_WIDTH-1:0] ext_data;

    assign acc_shift = {acc_q[DATA_WIDTH-9:0], mem_data_out};

    memseq_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_extend (
        .data_i  (acc_shift),
        .size_i  (size_q),
        .signed_i(signed_q),
        .data_o  (ext_data)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        wsh_d    = wsh_q;
        acc_d    = acc_q;
        size_d   = size_q;
        signed_d = signed_q;
        err_d    = err_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    err_d    = 1'b0;
                    acc_d    = '0;
                    cnt_d    = size_bytes(req_size) - 4'd1;
                    if (size_bytes(req_size) > MaxBytes) begin
                        // Address and data left untouched: no memory access at all.
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (req_write) begin
                        addr_d  = req_addr;
                        // Left-align so the most significant byte sits at the top.
                        wsh_d   = req_wdata << (DATA_WIDTH - 32'(size_bytes(req_size)) * 8);
                        state_d = StWsetup;
                    end else begin
                        addr_d  = req_addr;
                        state_d = StRaddr;
                    end
                end
            end
            StRaddr: begin
                if (WAIT_STATES == 0) begin
                    state_d = StRsample;
                end else begin
                    wait_d  = WaitInit;
                    state_d = StRwait;
                end
            end
            StRwait: begin
                if (wait_q == 3'd0) begin
                    state_d = StRsample;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            StRsample: begin
                if (mem_ready) begin
                    acc_d = acc_shift;
                    if (cnt_q == 4'd0) begin
                        rdata_d = ext_data;
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        addr_d  = addr_q + 1'b1;
                        state_d = StRaddr;
                    end
                end
            end
            StWsetup: begin
                state_d = StWstrobe;
            end
            StWstrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    addr_d  = addr_q + 1'b1;
                    wsh_d   = wsh_q << 8;
                    state_d = StWsetup;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            wsh_q    <= '0;
            acc_q    <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            wsh_q    <= wsh_d;
            acc_q    <= acc_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StDone);
    assign rsp_err     = (state_q == StDone) && err_q;
    assign rsp_rdata   = rdata_q;
    assign mem_write   = (state_q == StWstrobe);
    assign mem_raddr   = addr_q;
    assign mem_waddr   = addr_q;
    assign mem_data_in = wsh_q[DATA_WIDTH-1 -: 8];

endmodule

// File: doc/memseq.md
MEMSEQ -- requirements
Module: memseq

Interface
REQ-001 Parameter ADDR_WIDTH, 9, byte-address width of the memory port.
REQ-002 Parameter DATA_WIDTH, 32, register data width; SHALL be 32 or 64.
REQ-003 Parameter WAIT_STATES, 1, idle cycles between driving mem_raddr and sampling mem_data_out; range 0..7.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 req_valid  in  1  request offered.
REQ-007 req_ready  out  1  high only in IDLE; a transfer is accepted when req_valid & req_ready.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  0 = byte, 1 = 16-bit, 2 = 32-bit, 3 = 64-bit.
REQ-010 req_signed  in  1  load result sign-extended (see Configuration).
REQ-011 req_addr  in  ADDR_WIDTH  address of the most significant byte.
REQ-012 req_wdata  in  DATA_WIDTH  store data, right-aligned.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_rdata  out  DATA_WIDTH  load result, right-aligned; held until the next load completes.
REQ-015 rsp_err  out  1  valid with rsp_valid; 1 = unsupported size.
REQ-016 mem_raddr / mem_waddr  out  ADDR_WIDTH  memory read / write address.
REQ-017 mem_data_in  out  8  byte to memory; mem_data_out  in  8  byte from memory.
REQ-018 mem_write  out  1  one-cycle write strobe; mem_ready  in  1  read data valid.

Function
REQ-019 Byte order SHALL be big-endian: byte k of an N-byte transfer uses address req_addr+k, MSB first.
REQ-020 Address increments SHALL wrap modulo 2^ADDR_WIDTH (e.g. 0x1FF -> 0x000).
REQ-021 States SHALL be IDLE, RADDR, RWAIT, RSAMPLE, WSETUP, WSTROBE, DONE.
REQ-022 IDLE -> RADDR (load), WSETUP (store), or DONE with rsp_err=1 if 2^req_size > DATA_WIDTH/8; request fields are latched on acceptance.
REQ-023 RADDR drives mem_raddr for one cycle, then RWAIT for WAIT_STATES cycles (skipped if 0), then RSAMPLE.
REQ-024 RSAMPLE SHALL capture mem_data_out only when mem_ready=1, otherwise stay in RSAMPLE (unbounded stall); after capture -> RADDR for the next byte, or DONE after the last byte.
REQ-025 WSETUP drives mem_waddr and mem_data_in; WSTROBE asserts mem_write for exactly one cycle with address and data stable; then -> WSETUP for the next byte, or DONE.
REQ-026 DONE asserts rsp_valid for one cycle and returns to IDLE; back-to-back requests lose no further cycle.
REQ-027 Latency, acceptance to rsp_valid with mem_ready=1: load = N*(WAIT_STATES+2)+1 cycles; store = 2N+1; error = 1.
REQ-028 A store SHALL not alter rsp_rdata; an errored request SHALL cause no memory access.
REQ-029 mem_write SHALL never assert outside WSTROBE.

Reset
REQ-030 On reset: state IDLE; req_ready=1 after release; rsp_valid, rsp_err, mem_write=0; rsp_rdata, mem_raddr, mem_waddr, mem_data_in=0.
REQ-031 Reset mid-transfer SHALL abort immediately, with no further strobe and no rsp_valid for the aborted request.

Configuration
REQ-032 With MEMSEQ_SIGNEXT_EN defined, a load with req_signed=1 SHALL sign-extend from the top bit of the loaded size.
REQ-033 Without MEMSEQ_SIGNEXT_EN, req_signed SHALL be ignored and every load zero-extended.

Structure
REQ-034 Package memseq_pkg SHALL hold the state enum, the req_size encodings and a size-to-byte-count function.
REQ-035 Sub-module memseq_extend (combinational, width-parametrised) SHALL perform zero/sign extension.

Verification
REQ-036 Store 32-bit 0xDEADBEEF at 0x010 -> four strobes, bytes DE,AD,BE,EF at 0x010..0x013, rsp_valid 9 cycles after acceptance.
REQ-037 Load 32-bit from 0x010 after REQ-036, WAIT_STATES=1 -> rsp_rdata=0xDEADBEEF, rsp_err=0, 13 cycles.
REQ-038 Load 16-bit from 0x1FF with bytes 0x80 at 0x1FF and 0x01 at 0x000, req_signed=1 -> reads wrap; 0xFFFF8001 with macro, 0x00008001 without.
REQ-039 Hold mem_ready=0 for 5 cycles on byte 2 of a 32-bit load -> state held in RSAMPLE, result correct, latency +5.
REQ-040 req_size=3 with DATA_WIDTH=32 -> rsp_err=1 one cycle after acceptance, no mem_write, rsp_rdata unchanged.
REQ-041 Assert reset during byte 2 of a 32-bit store -> mem_write low at once, no rsp_valid, req_ready=1 after release.
